fnd_scan_controller: RTL and testbench

//  Time-multiplexes DIGITS BCD digits onto one shared BCD-to-FND segment decoder and a common-anode

---
 rtl/fnd_scan_controller_pkg.sv | 22 ++
 rtl/fnd_slot_timer.sv | 40 ++++
 rtl/fnd_scan_controller.sv | 113 +++++++++++
 tb/tb_fnd_scan_controller.sv | 148 ++++++++++++++
 4 files changed

// File: rtl/fnd_scan_controller_pkg.sv
// Shared types and constants for the FND scan controller and its slot timer.
package fnd_scan_controller_pkg;

  typedef enum logic {
    ST_GAP  = 1'b0,
    ST_SHOW = 1'b1
  } scan_state_e;

  localparam logic [3:0] BCD_ZERO = 4'h0;
  localparam logic [3:0] BCD_DOT  = 4'hA;

  // Counter width for a modulus n; never narrower than one bit.
  function automatic int width_of(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  localparam int DEF_DIGITS       = 4;
  localparam int DEF_DIGIT_CYCLES = 100000;
  localparam int DEF_CNT_W        = $clog2(DEF_DIGIT_CYCLES);
  localparam int DEF_IDX_W        = $clog2(DEF_DIGITS);

endpackage

// File: rtl/fnd_slot_timer.sv
// Slot counter and digit index; flags the last cycle of the last slot in a frame.
module fnd_slot_timer #(
  parameter int DIGITS       = 4,
  parameter int DIGIT_CYCLES = 100000,
  parameter int CNT_W        = 17,
  parameter int IDX_W        = 2
) (
  input  logic             i_clk,
  input  logic             i_reset_n,
  output logic [CNT_W-1:0] o_cnt,
  output logic [IDX_W-1:0] o_idx,
  output logic             o_boundary
);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic             wrap;

  always_comb begin
    wrap       = (cnt_q == CNT_W'(DIGIT_CYCLES - 1));
    o_boundary = wrap && (idx_q == IDX_W'(DIGITS - 1));
    cnt_d      = wrap ? '0 : cnt_q + 1'b1;
    idx_d      = idx_q;
    if (wrap) idx_d = o_boundary ? '0 : idx_q + 1'b1;
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      cnt_q <= '0;
      idx_q <= '0;
    end else begin
      cnt_q <= cnt_d;
      idx_q <= idx_d;
    end
  end

  assign o_cnt = cnt_q;
  assign o_idx = idx_q;

endmodule

// File: rtl/fnd_scan_controller.sv
// Multiplexes DIGITS BCD codes onto one shared decoder with blank gaps,
// leading-zero suppression and frame-aligned double-buffered loads.
module fnd_scan_controller
  import fnd_scan_controller_pkg::*;
#(
  parameter int DIGITS       = 4,
  parameter int DIGIT_CYCLES = 100000,
  parameter int BLANK_CYCLES = 1000
) (
  input  logic                  i_clk,
  input  logic                  i_reset_n,
  input  logic [4*DIGITS-1:0]   i_digits,
  input  logic                  i_load,
  input  logic                  i_zero_supp,
  output logic [3:0]            o_value,
  output logic                  o_blank,
  output logic [DIGITS-1:0]     o_digit_sel,
  output logic                  o_frame_done
);

  localparam int CNT_W = width_of(DIGIT_CYCLES);
  localparam int IDX_W = width_of(DIGITS);

  logic [CNT_W-1:0] cnt;
  logic [IDX_W-1:0] idx;
  logic             boundary;

  fnd_slot_timer #(
    .DIGITS       (DIGITS),
    .DIGIT_CYCLES (DIGIT_CYCLES),
    .CNT_W        (CNT_W),
    .IDX_W        (IDX_W)
  ) u_timer (
    .i_clk      (i_clk),
    .i_reset_n  (i_reset_n),
    .o_cnt      (cnt),
    .o_idx      (idx),
    .o_boundary (boundary)
  );

  logic [DIGITS-1:0][3:0] shadow_q, shadow_d;
  logic [DIGITS-1:0][3:0] active_q, active_d;
  logic [DIGITS-1:0]      supp;
  logic                   zero_run;

  scan_state_e       state_q, state_d;
  logic [DIGITS-1:0] sel_q, sel_d;
  logic [3:0]        value_q, value_d;
  logic              blank_q, blank_d;
  logic              frame_done_q, frame_done_d;

  // A boundary-cycle load goes straight to the active copy so it is not lost.
  always_comb begin
    shadow_d = i_load ? i_digits : shadow_q;
    active_d = active_q;
    if (boundary) active_d = i_load ? i_digits : shadow_q;
  end

  // Digit k>0 is a leading zero when it and every digit above it are zero.
  always_comb begin
    supp     = '0;
    zero_run = 1'b1;
    for (int k = DIGITS - 1; k > 0; k--) begin
      zero_run = zero_run && (active_q[k] == BCD_ZERO);
      supp[k]  = i_zero_supp && zero_run;
    end
  end

  // state_q tracks the phase currently on the outputs, i.e. one cycle behind cnt.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_GAP:  if (cnt == CNT_W'(BLANK_CYCLES)) state_d = ST_SHOW;
      ST_SHOW: if (cnt == '0)                   state_d = ST_GAP;
      default:                                  state_d = ST_GAP;
    endcase
    sel_d        = '1;
    value_d      = BCD_ZERO;
    blank_d      = 1'b1;
    frame_done_d = boundary;
    if (state_d == ST_SHOW) begin
      sel_d[idx] = 1'b0;
      value_d    = active_q[idx];
      blank_d    = supp[idx];
    end
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      shadow_q     <= '0;
      active_q     <= '0;
      state_q      <= ST_GAP;
      sel_q        <= '1;
      value_q      <= BCD_ZERO;
      blank_q      <= 1'b1;
      frame_done_q <= 1'b0;
    end else begin
      shadow_q     <= shadow_d;
      active_q     <= active_d;
      state_q      <= state_d;
      sel_q        <= sel_d;
      value_q      <= value_d;
      blank_q      <= blank_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign o_digit_sel  = sel_q;
  assign o_value      = value_q;
  assign o_blank      = blank_q;
  assign o_frame_done = frame_done_q;

endmodule

// File: tb/tb_fnd_scan_controller.sv
// Directed bench for fnd_scan_controller with DIGITS=4, DIGIT_CYCLES=8, BLANK_CYCLES=2.
module tb_fnd_scan_controller;

  localparam int D  = 4;
  localparam int DC = 8;
  localparam int BC = 2;
  localparam int FR = D * DC;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [4*D-1:0] digits = '0;
  logic          load = 1'b0;
  logic          zs = 1'b0;
  logic [3:0]    o_value;
  logic          o_blank;
  logic [D-1:0]  o_digit_sel;
  logic          o_frame_done;

  fnd_scan_controller #(
    .DIGITS       (D),
    .DIGIT_CYCLES (DC),
    .BLANK_CYCLES (BC)
  ) dut (
    .i_clk        (clk),
    .i_reset_n    (rst_n),
    .i_digits     (digits),
    .i_load       (load),
    .i_zero_supp  (zs),
    .o_value      (o_value),
    .o_blank      (o_blank),
    .o_digit_sel  (o_digit_sel),
    .o_frame_done (o_frame_done)
  );

  always #5 clk = ~clk;

  int k;
  int n_chk;
  int n_pass;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h want %0h", tag, obs, exp);
  endtask

  // Advance one clock, sample 1 time unit later and check the select invariant.
  task automatic step();
    @(posedge clk);
    #1;
    k++;
    chk("sel_le1", ($countones(~o_digit_sel) <= 1) ? 32'd1 : 32'd0, 32'd1);
  endtask

  task automatic ld(input logic [4*D-1:0] v);
    digits = v;
    load   = 1'b1;
    step();
    load   = 1'b0;
  endtask

  // Check one whole output frame against hand-given digits and blank mask;
  // optionally strobe a load at frame cycle load_at.
  task automatic check_frame(input logic [4*D-1:0] exp, input logic [D-1:0] mask,
                             input int load_at, input logic [4*D-1:0] lval);
    while (k % FR != 0) step();
    for (int j = 0; j < FR; j++) begin
      int c;
      int d;
      logic [D-1:0] esel;
      if (j == load_at) begin
        digits = lval;
        load   = 1'b1;
      end
      step();
      load = 1'b0;
      c = j % DC;
      d = j / DC;
      if (c < BC) begin
        chk($sformatf("gap_d%0d_c%0d", d, c), {27'd0, o_digit_sel, o_blank}, {27'd0, 4'hF, 1'b1});
      end else begin
        esel = ~(D'(1) << d);
        chk($sformatf("show_d%0d_c%0d", d, c), {23'd0, o_digit_sel, o_blank, o_value},
            {23'd0, esel, mask[d], exp[4*d +: 4]});
      end
      chk("frame_done", {31'd0, o_frame_done}, (j == FR - 1) ? 32'd1 : 32'd0);
    end
  endtask

  initial begin
    k = 0; n_chk = 0; n_pass = 0;
    #12;
    chk("rst_sel",   {28'd0, o_digit_sel}, 32'hF);
    chk("rst_blank", {31'd0, o_blank}, 32'd1);
    chk("rst_value", {28'd0, o_value}, 32'd0);
    chk("rst_fdone", {31'd0, o_frame_done}, 32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    k = 0;

    ld(16'h4321);
    check_frame(16'h4321, 4'b0000, -1, '0);
    check_frame(16'h4321, 4'b0000, -1, '0);

    ld(16'h0070);
    zs = 1'b1;
    check_frame(16'h0070, 4'b1100, -1, '0);
    zs = 1'b0;
    check_frame(16'h0070, 4'b0000, -1, '0);

    ld(16'h1111);
    check_frame(16'h1111, 4'b0000, -1, '0);
    check_frame(16'h1111, 4'b0000, 12, 16'h9999);
    check_frame(16'h9999, 4'b0000, -1, '0);

    check_frame(16'h9999, 4'b0000, FR - 1, 16'h5555);
    check_frame(16'h5555, 4'b0000, -1, '0);

    zs = 1'b1;
    ld(16'h000A);
    check_frame(16'h000A, 4'b1110, -1, '0);
    ld(16'hFB00);
    check_frame(16'hFB00, 4'b0000, -1, '0);
    ld(16'h1000);
    check_frame(16'h1000, 4'b0000, -1, '0);
    ld(16'h0100);
    check_frame(16'h0100, 4'b1000, -1, '0);

    // Reset in the middle of a SHOW slot.
    while (k % DC != 4) step();
    chk("pre_rst_show", {28'd0, o_digit_sel} != 32'hF ? 32'd1 : 32'd0, 32'd1);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_now", {23'd0, o_digit_sel, o_blank, o_value, o_frame_done}, {23'd0, 4'hF, 1'b1, 4'h0, 1'b0});
    @(posedge clk);
    #1;
    chk("mid_rst_hold", {23'd0, o_digit_sel, o_blank, o_value, o_frame_done}, {23'd0, 4'hF, 1'b1, 4'h0, 1'b0});
    rst_n = 1'b1;
    zs = 1'b0;
    k = 0;
    check_frame(16'h0000, 4'b0000, -1, '0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
